// File: rtl/uart_pkt_pkg.sv
// Shared types and constants for the UART packet framing stage.
package uart_pkt_pkg;

  typedef enum logic [2:0] {
    ST_HUNT    = 3'd0,
    ST_LEN     = 3'd1,
    ST_PAYLOAD = 3'd2,
    ST_CHECK   = 3'd3,
    ST_DRAIN   = 3'd4
  } state_e;

  localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;
  localparam int         CHK_W             = 8;

  // Running checksum is a plain modulo-256 sum.
  function automatic logic [CHK_W-1:0] chk_add(input logic [CHK_W-1:0] acc,
                                                input logic [7:0]       b);
    return acc + CHK_W'(b);
  endfunction

endpackage

// File: rtl/uart_packet_rx_if.sv
// Byte-in / payload-out signal bundle of the packet framer; slave is the framer side.
interface uart_packet_rx_if;

  logic       i_RX_DV;
  logic [7:0] i_RX_Byte;
  logic [7:0] o_Data;
  logic       o_Data_Valid;
  logic       i_Data_Ready;
  logic       o_Data_Last;
  logic [7:0] o_Pkt_Len;
  logic       o_Err_Chk;
  logic       o_Err_Len;
  logic       o_Err_Timeout;
  logic       o_Err_Overrun;
  logic [2:0] o_State;

  modport slave (
    input  i_RX_DV, i_RX_Byte, i_Data_Ready,
    output o_Data, o_Data_Valid, o_Data_Last, o_Pkt_Len,
    output o_Err_Chk, o_Err_Len, o_Err_Timeout, o_Err_Overrun, o_State
  );

  modport master (
    output i_RX_DV, i_RX_Byte, i_Data_Ready,
    input  o_Data, o_Data_Valid, o_Data_Last, o_Pkt_Len,
    input  o_Err_Chk, o_Err_Len, o_Err_Timeout, o_Err_Overrun, o_State
  );

endinterface

// File: rtl/uart_byte_strobe.sv
// Turns the receiver's level-style byte-valid into a one-cycle strobe per byte.
module uart_byte_strobe (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       rx_dv_i,
  input  logic [7:0] rx_byte_i,
  output logic       strobe_o,
  output logic [7:0] byte_o
);

  logic       dv_q;
  logic [7:0] byte_q;

  // dv_q resets high so a valid level held through reset is not taken as a new byte.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      dv_q   <= 1'b1;
      byte_q <= 8'h00;
    end else begin
      dv_q <= rx_dv_i;
      if (strobe_o) begin
        byte_q <= rx_byte_i;
      end
    end
  end

  assign strobe_o = rx_dv_i & ~dv_q;
  assign byte_o   = strobe_o ? rx_byte_i : byte_q;

endmodule

// File: rtl/uart_packet_rx.sv
// Packet framer: hunts for sync, buffers a length-prefixed checksummed frame,
// then drains the payload over valid/ready with one-cycle error pulses.
module uart_packet_rx
  import uart_pkt_pkg::*;
#(
  parameter int         MAX_LEN      = 16,
  parameter logic [7:0] SYNC_BYTE    = DEFAULT_SYNC_BYTE,
  parameter int         TIMEOUT_CLKS = 50000
) (
  input logic             i_Clock,
  input logic             i_Reset,
  uart_packet_rx_if.slave bus
);

  localparam int IDX_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int TMR_W = (TIMEOUT_CLKS > 1) ? $clog2(TIMEOUT_CLKS) : 1;

  logic             strobe_s;
  logic [7:0]       byte_s;
  logic             timeout_s;
  logic             buf_we_s;
  logic             drain_s;

  state_e           state_q, state_d;
  logic [7:0]       len_q, len_d;
  logic [IDX_W-1:0] last_idx_q, last_idx_d;
  logic [IDX_W-1:0] wr_idx_q, wr_idx_d;
  logic [IDX_W-1:0] rd_idx_q, rd_idx_d;
  logic [CHK_W-1:0] chk_q, chk_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic [7:0]       buf_q [MAX_LEN];

  logic [7:0]       data_q, data_d;
  logic             valid_q, valid_d;
  logic             last_q, last_d;
  logic [7:0]       pkt_len_q, pkt_len_d;
  logic             err_chk_q, err_chk_d;
  logic             err_len_q, err_len_d;
  logic             err_tmo_q, err_tmo_d;
  logic             err_ovr_q, err_ovr_d;

  uart_byte_strobe u_strobe (
    .clk_i     (i_Clock),
    .rst_i     (i_Reset),
    .rx_dv_i   (bus.i_RX_DV),
    .rx_byte_i (bus.i_RX_Byte),
    .strobe_o  (strobe_s),
    .byte_o    (byte_s)
  );

  assign timeout_s = (timer_q == TMR_W'(TIMEOUT_CLKS - 1));

  // Next-state logic; a strobe always takes priority over an expiring timer.
  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    last_idx_d = last_idx_q;
    wr_idx_d   = wr_idx_q;
    rd_idx_d   = rd_idx_q;
    chk_d      = chk_q;
    timer_d    = timer_q;
    buf_we_s   = 1'b0;
    err_chk_d  = 1'b0;
    err_len_d  = 1'b0;
    err_tmo_d  = 1'b0;
    err_ovr_d  = 1'b0;
    case (state_q)
      ST_HUNT: begin
        if (strobe_s && (byte_s == SYNC_BYTE)) begin
          state_d = ST_LEN;
          timer_d = {TMR_W{1'b0}};
        end else begin
          state_d = ST_HUNT;
        end
      end
      ST_LEN, ST_PAYLOAD, ST_CHECK: begin
        if (strobe_s) begin
          timer_d = {TMR_W{1'b0}};
          if (state_q == ST_LEN) begin
            if ((byte_s == 8'd0) || (byte_s > 8'(MAX_LEN))) begin
              err_len_d = 1'b1;
              state_d   = ST_HUNT;
            end else begin
              len_d      = byte_s;
              last_idx_d = IDX_W'(byte_s - 8'd1);
              chk_d      = CHK_W'(byte_s);
              wr_idx_d   = {IDX_W{1'b0}};
              state_d    = ST_PAYLOAD;
            end
          end else if (state_q == ST_PAYLOAD) begin
            buf_we_s = 1'b1;
            chk_d    = chk_add(chk_q, byte_s);
            if (wr_idx_q == last_idx_q) begin
              state_d = ST_CHECK;
            end else begin
              wr_idx_d = wr_idx_q + IDX_W'(1);
            end
          end else begin
            if (byte_s == chk_q) begin
              rd_idx_d = {IDX_W{1'b0}};
              state_d  = ST_DRAIN;
            end else begin
              err_chk_d = 1'b1;
              state_d   = ST_HUNT;
            end
          end
        end else if (timeout_s) begin
          err_tmo_d = 1'b1;
          timer_d   = {TMR_W{1'b0}};
          state_d   = ST_HUNT;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      ST_DRAIN: begin
        err_ovr_d = strobe_s;
        if (bus.i_Data_Ready) begin
          if (rd_idx_q == last_idx_q) begin
            state_d = ST_HUNT;
          end else begin
            rd_idx_d = rd_idx_q + IDX_W'(1);
          end
        end else begin
          rd_idx_d = rd_idx_q;
        end
      end
      default: begin
        state_d = ST_HUNT;
      end
    endcase
  end

  // Output stream values are prepared from the next state so they leave a register.
  always_comb begin
    drain_s   = (state_d == ST_DRAIN);
    valid_d   = drain_s;
    data_d    = drain_s ? buf_q[rd_idx_d] : 8'h00;
    last_d    = drain_s && (rd_idx_d == last_idx_d);
    pkt_len_d = drain_s ? len_d : 8'h00;
  end

  // Control, datapath and output registers.
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      state_q    <= ST_HUNT;
      len_q      <= 8'h00;
      last_idx_q <= {IDX_W{1'b0}};
      wr_idx_q   <= {IDX_W{1'b0}};
      rd_idx_q   <= {IDX_W{1'b0}};
      chk_q      <= {CHK_W{1'b0}};
      timer_q    <= {TMR_W{1'b0}};
      data_q     <= 8'h00;
      valid_q    <= 1'b0;
      last_q     <= 1'b0;
      pkt_len_q  <= 8'h00;
      err_chk_q  <= 1'b0;
      err_len_q  <= 1'b0;
      err_tmo_q  <= 1'b0;
      err_ovr_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      last_idx_q <= last_idx_d;
      wr_idx_q   <= wr_idx_d;
      rd_idx_q   <= rd_idx_d;
      chk_q      <= chk_d;
      timer_q    <= timer_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      last_q     <= last_d;
      pkt_len_q  <= pkt_len_d;
      err_chk_q  <= err_chk_d;
      err_len_q  <= err_len_d;
      err_tmo_q  <= err_tmo_d;
      err_ovr_q  <= err_ovr_d;
    end
  end

  // Payload buffer.
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      for (int i = 0; i < MAX_LEN; i++) begin
        buf_q[i] <= 8'h00;
      end
    end else if (buf_we_s) begin
      buf_q[wr_idx_q] <= byte_s;
    end
  end

  assign bus.o_Data        = data_q;
  assign bus.o_Data_Valid  = valid_q;
  assign bus.o_Data_Last   = last_q;
  assign bus.o_Pkt_Len     = pkt_len_q;
  assign bus.o_Err_Chk     = err_chk_q;
  assign bus.o_Err_Len     = err_len_q;
  assign bus.o_Err_Timeout = err_tmo_q;
  assign bus.o_Err_Overrun = err_ovr_q;
  assign bus.o_State       = state_q;

endmodule

// File: tb/tb_uart_packet_rx.sv
// Scoreboard bench for uart_packet_rx: stimulus pushes expected payload, a negedge monitor checks it.
module tb_uart_packet_rx;

  localparam int TB_TIMEOUT = 4000;

  typedef logic [7:0] bq_t[$];
  typedef struct packed {
    logic [7:0] data;
    logic       last;
    logic [7:0] len;
  } exp_t;

  logic clk;
  logic rst;
  uart_packet_rx_if bus();

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;
  int   err_cnt[4] = '{default: 0};
  int   exp_err[4] = '{default: 0};
  logic [3:0] prev_errs = 4'd0;
  logic rdy_level = 1'b1;
  logic toggle_en = 1'b0;

  uart_packet_rx #(
    .MAX_LEN      (16),
    .SYNC_BYTE    (8'hA5),
    .TIMEOUT_CLKS (TB_TIMEOUT)
  ) dut (
    .i_Clock (clk),
    .i_Reset (rst),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_idle(input string name);
    chk({name, "_outs"}, 32'({bus.o_Data, bus.o_Data_Valid, bus.o_Data_Last, bus.o_Pkt_Len,
                              bus.o_Err_Chk, bus.o_Err_Len, bus.o_Err_Timeout, bus.o_Err_Overrun}), 32'd0);
    chk({name, "_state"}, 32'(bus.o_State), 32'd0);
  endtask

  task automatic check_errs(input string name);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("%s_errcnt%0d", name, i), 32'(err_cnt[i]), 32'(exp_err[i]));
    end
    chk({name, "_sb_empty"}, 32'(sb_q.size()), 32'd0);
  endtask

  task automatic send_byte(input logic [7:0] b, input int hold);
    @(posedge clk); #1;
    bus.i_RX_Byte = b;
    bus.i_RX_DV   = 1'b1;
    repeat (hold) @(posedge clk);
    #1;
    bus.i_RX_DV = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  task automatic send_seq(input bq_t seq, input int hold);
    foreach (seq[i]) send_byte(seq[i], hold);
  endtask

  task automatic expect_pkt(input bq_t payload);
    foreach (payload[i]) begin
      sb_q.push_back('{data: payload[i], last: (i == payload.size() - 1), len: 8'(payload.size())});
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset(input string name);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    sb_q.delete();
    @(negedge clk);
    check_idle({name, "_in"});
    @(negedge clk);
    check_idle({name, "_after"});
  endtask

  // Ready driver: constant level or toggling every cycle.
  initial begin
    bus.i_Data_Ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      bus.i_Data_Ready = toggle_en ? ~bus.i_Data_Ready : rdy_level;
    end
  end

  // Monitor: scoreboard compare on every valid cycle, pop on transfer, error pulse bookkeeping.
  always @(negedge clk) begin
    logic [3:0] errs;
    errs = {bus.o_Err_Overrun, bus.o_Err_Timeout, bus.o_Err_Len, bus.o_Err_Chk};
    if (errs != 4'd0) begin
      chk("err_onehot", 32'($countones(errs)), 32'd1);
      chk("err_one_cycle", 32'(errs & prev_errs), 32'd0);
      for (int i = 0; i < 4; i++) begin
        if (errs[i]) err_cnt[i]++;
      end
    end
    prev_errs = errs;
    if (bus.o_Data_Valid) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_valid: got data %02h with empty scoreboard", bus.o_Data);
      end else begin
        chk("data", 32'(bus.o_Data), 32'(sb_q[0].data));
        chk("last", 32'(bus.o_Data_Last), 32'(sb_q[0].last));
        chk("pkt_len", 32'(bus.o_Pkt_Len), 32'(sb_q[0].len));
        if (bus.i_Data_Ready) void'(sb_q.pop_front());
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bq_t seq;
    bq_t pay;
    rst           = 1'b1;
    bus.i_RX_DV   = 1'b0;
    bus.i_RX_Byte = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_idle("reset");
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check_idle("post_reset");

    // Good packet, ready held high.
    pay = {8'h11, 8'h22, 8'h33};
    expect_pkt(pay);
    seq = {8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h69};
    send_seq(seq, 1);
    idle(10);
    check_errs("good");

    // Bad checksum followed by a good packet.
    seq = {8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h6A};
    send_seq(seq, 1);
    idle(5);
    exp_err[0]++;
    check_errs("bad_chk");
    chk("bad_chk_state", 32'(bus.o_State), 32'd0);
    expect_pkt(pay);
    seq = {8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h69};
    send_seq(seq, 1);
    idle(10);
    check_errs("after_bad_chk");

    // Length zero and length above maximum; junk between is ignored.
    seq = {8'hA5, 8'h00};
    send_seq(seq, 1);
    idle(3);
    exp_err[1]++;
    check_errs("len0");
    chk("len0_state", 32'(bus.o_State), 32'd0);
    seq = {8'h11, 8'h22, 8'hA5, 8'h11, 8'h33};
    send_seq(seq, 1);
    idle(3);
    exp_err[1]++;
    check_errs("len17");
    chk("len17_state", 32'(bus.o_State), 32'd0);
    expect_pkt(pay);
    seq = {8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h69};
    send_seq(seq, 1);
    idle(10);
    check_errs("after_len");

    // Inter-byte timeout, then a single-byte packet.
    seq = {8'hA5, 8'h02, 8'h11};
    send_seq(seq, 1);
    idle(TB_TIMEOUT - 20);
    check_errs("tmo_early");
    chk("tmo_early_state", 32'(bus.o_State), 32'd2);
    idle(40);
    exp_err[2]++;
    check_errs("tmo");
    chk("tmo_state", 32'(bus.o_State), 32'd0);
    pay = {8'h7E};
    expect_pkt(pay);
    seq = {8'hA5, 8'h01, 8'h7E, 8'h7F};
    send_seq(seq, 1);
    idle(10);
    check_errs("after_tmo");

    // Long DV levels, stalled drain with overrun bytes, then toggling ready.
    seq = {8'hA5, 8'h02, 8'h44, 8'h55};
    send_seq(seq, 1000);
    rdy_level = 1'b0;
    pay = {8'h44, 8'h55};
    expect_pkt(pay);
    send_byte(8'h9B, 1000);
    seq = {8'h05, 8'h06};
    send_seq(seq, 1000);
    @(negedge clk);
    chk("ovr_state", 32'(bus.o_State), 32'd4);
    chk("ovr_pending", 32'(sb_q.size()), 32'd2);
    exp_err[3] += 2;
    toggle_en = 1'b1;
    idle(12);
    toggle_en = 1'b0;
    rdy_level = 1'b1;
    idle(5);
    check_errs("ovr");
    chk("ovr_done_state", 32'(bus.o_State), 32'd0);

    // Reset mid-payload.
    seq = {8'hA5, 8'h03, 8'h11};
    send_seq(seq, 1);
    @(negedge clk);
    chk("rst_pay_state", 32'(bus.o_State), 32'd2);
    do_reset("rst_pay");
    pay = {8'h7E};
    expect_pkt(pay);
    seq = {8'hA5, 8'h01, 8'h7E, 8'h7F};
    send_seq(seq, 1);
    idle(10);
    check_errs("after_rst_pay");

    // Reset mid-drain.
    rdy_level = 1'b0;
    expect_pkt(pay);
    send_seq(seq, 1);
    idle(3);
    chk("rst_drain_state", 32'(bus.o_State), 32'd4);
    do_reset("rst_drain");
    rdy_level = 1'b1;
    pay = {8'h11, 8'h22, 8'h33};
    expect_pkt(pay);
    seq = {8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h69};
    send_seq(seq, 1);
    idle(10);
    check_errs("final");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
